// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Supervises a Gowin rPLL from its reference clock domain.
//               Pulses the PLL RESET input, waits for the asynchronous lock
//               output, and only releases a clean active-low reset and ready
//               flag once lock has been continuously high for STABLE_CYCLES.
//               A lock that never arrives within LOCK_TIMEOUT re-pulses the
//               PLL. Lock losses while running are counted.
// Ports       : clk         in  reference clock (also feeds PLL clkin)
//               rst_n       in  asynchronous active-low reset
//               lock        in  PLL lock, asynchronous to clk
//               pll_reset   out PLL RESET, active high
//               sys_rst_n   out downstream reset, active low
//               ready       out high while running
//               timeout_err out sticky lock-timeout flag
//               retry_cnt   out saturating timeout-retry count
//               loss_cnt    out saturating lock-loss count
// Options     : PLL_SUP_LOSS_CNT_EN - when defined, loss_cnt is a live
//               counter; otherwise the port is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 2500000,
    parameter int STABLE_CYCLES  = 250000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lock,
    output logic             pll_reset,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    // One shared counter, wide enough for the longest phase.
    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] C_RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] C_TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] C_STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] C_CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lock_meta_q, lock_s_q;
    logic             pll_reset_q, pll_reset_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             ready_q, ready_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        retry_cnt_d   = retry_cnt_q;
        case (state_q)
            ST_PLL_RST: begin
                // lock is deliberately ignored while the PLL is held in reset
                if (cnt_q == C_RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                // lock has priority over a coincident timeout
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_TO_LAST) begin
                    state_d       = ST_PLL_RST;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                    if (retry_cnt_q != {CNT_W{1'b1}}) begin
                        retry_cnt_d = retry_cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_STABLE: begin
                // a drop, even on the final count, restarts the lock wait
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == C_STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the
        // same edge as the state itself; sys_rst_n can only be high in RUN.
        pll_reset_d = (state_d == ST_PLL_RST);
        sys_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_PLL_RST;
            cnt_q         <= '0;
            lock_meta_q   <= 1'b0;
            lock_s_q      <= 1'b0;
            pll_reset_q   <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            ready_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            retry_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lock_meta_q   <= lock;
            lock_s_q      <= lock_meta_q;
            pll_reset_q   <= pll_reset_d;
            sys_rst_n_q   <= sys_rst_n_d;
            ready_q       <= ready_d;
            timeout_err_q <= timeout_err_d;
            retry_cnt_q   <= retry_cnt_d;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign ready       = ready_q;
    assign timeout_err = timeout_err_q;
    assign retry_cnt   = retry_cnt_q;

`ifdef PLL_SUP_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic             loss_event;

    assign loss_event = (state_q == ST_RUN) && !lock_s_q;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_event && (loss_cnt_q != {CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`else
    assign loss_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Self-checking bench for pll_lock_supervisor with
//               PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, CNT_W=4.
//               Edge e is the e-th rising clk edge after rst_n release;
//               lock is changed and outputs sampled 1 ns after an edge.
// Options     : PLL_SUP_LOSS_CNT_EN selects the expected loss_cnt model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    localparam int CNT_W = 4;
`ifdef PLL_SUP_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             lock  = 1'b0;
    logic             pll_reset;
    logic             sys_rst_n;
    logic             ready;
    logic             timeout_err;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic lock;
        logic pll_reset;
        logic run;
        logic timeout_err;
    } vec_t;

    vec_t vecs [24];

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lock        (lock),
        .pll_reset   (pll_reset),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .timeout_err (timeout_err),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int exp_loss(input int n);
        if (!LOSS_EN) return 0;
        return (n > 15) ? 15 : n;
    endfunction

    // Asserts rst_n away from any edge, checks the asynchronous reset
    // values before the next edge, then releases 1 ns after an edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, " rst pll_reset"},   32'(pll_reset),   32'd1);
        chk({tag, " rst sys_rst_n"},   32'(sys_rst_n),   32'd0);
        chk({tag, " rst ready"},       32'(ready),       32'd0);
        chk({tag, " rst timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, " rst retry_cnt"},   32'(retry_cnt),   32'd0);
        chk({tag, " rst loss_cnt"},    32'(loss_cnt),    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // With lock held high: 4-cycle pll_reset, STABLE at edge 5, RUN at edge 13.
    task automatic restart_to_run(input string tag);
        for (int e = 1; e <= 13; e++) begin
            step(1);
            chk({tag, " pll_reset"}, 32'(pll_reset), 32'(e < 4));
            chk({tag, " sys_rst_n"}, 32'(sys_rst_n), 32'(e >= 13));
        end
    endtask

    initial begin
        // Scenario 1 table: lock rises before edge 11, lock_s high after
        // edge 12, STABLE entered at edge 13, RUN at edge 21 (index 20).
        for (int i = 0; i < 24; i++) begin
            vecs[i].lock        = (i >= 10);
            vecs[i].pll_reset   = (i < 3);
            vecs[i].run         = (i >= 20);
            vecs[i].timeout_err = 1'b0;
        end

        #2;
        // ---------------- Scenario 1: normal lock-up -----------------------
        lock = 1'b0;
        do_reset("s1");
        for (int i = 0; i < 24; i++) begin
            lock = vecs[i].lock;
            step(1);
            chk($sformatf("s1[%0d] pll_reset", i),   32'(pll_reset),   32'(vecs[i].pll_reset));
            chk($sformatf("s1[%0d] sys_rst_n", i),   32'(sys_rst_n),   32'(vecs[i].run));
            chk($sformatf("s1[%0d] ready", i),       32'(ready),       32'(vecs[i].run));
            chk($sformatf("s1[%0d] timeout_err", i), 32'(timeout_err), 32'(vecs[i].timeout_err));
        end
        chk("s1 retry_cnt", 32'(retry_cnt), 32'd0);
        chk("s1 loss_cnt",  32'(loss_cnt),  32'd0);

        // ---------------- Scenario 2: lock never arrives -------------------
        lock = 1'b0;
        do_reset("s2");
        for (int e = 1; e <= 408; e++) begin
            step(1);
            chk($sformatf("s2 e%0d pll_reset", e),   32'(pll_reset),   32'((e % 24) < 4));
            chk($sformatf("s2 e%0d retry_cnt", e),   32'(retry_cnt),   32'((e / 24) > 15 ? 15 : (e / 24)));
            chk($sformatf("s2 e%0d timeout_err", e), 32'(timeout_err), 32'(e >= 24));
            chk($sformatf("s2 e%0d sys_rst_n", e),   32'(sys_rst_n),   32'd0);
        end

        // ---------------- Scenario 5a: reset mid-STABLE --------------------
        // Edge 408 re-entered PLL_RST; with lock high STABLE begins 5 edges on.
        lock = 1'b1;
        step(7);
        chk("s5a pre sys_rst_n", 32'(sys_rst_n), 32'd0);
        chk("s5a pre retry_cnt", 32'(retry_cnt), 32'd15);
        do_reset("s5a");
        restart_to_run("s5a");

        // ---------------- Scenario 3: one-cycle glitch in STABLE -----------
        // lock low before edge 9 only -> lock_s low while cnt==5, back to
        // WAIT_LOCK at edge 11, STABLE again at edge 12, RUN at edge 20.
        lock = 1'b1;
        do_reset("s3");
        for (int e = 1; e <= 20; e++) begin
            lock = (e == 9) ? 1'b0 : 1'b1;
            step(1);
            chk($sformatf("s3 e%0d sys_rst_n", e), 32'(sys_rst_n), 32'(e >= 20));
            chk($sformatf("s3 e%0d ready", e),     32'(ready),     32'(e >= 20));
        end
        chk("s3 loss_cnt",    32'(loss_cnt),    32'd0);
        chk("s3 timeout_err", 32'(timeout_err), 32'd0);

        // ---------------- Corner: drop on final STABLE count ---------------
        // lock_s low only while cnt==7 -> WAIT_LOCK at 13, STABLE 14, RUN 22.
        lock = 1'b1;
        do_reset("cs");
        for (int e = 1; e <= 22; e++) begin
            lock = (e == 11) ? 1'b0 : 1'b1;
            step(1);
            chk($sformatf("cs e%0d ready", e), 32'(ready), 32'(e >= 22));
        end

        // ---------------- Corner: lock on the timeout cycle ----------------
        // lock_s rises after edge 23, exactly when cnt==19; lock must win.
        lock = 1'b0;
        do_reset("cw");
        for (int e = 1; e <= 32; e++) begin
            lock = (e >= 22);
            step(1);
            chk($sformatf("cw e%0d pll_reset", e),   32'(pll_reset),   32'(e < 4));
            chk($sformatf("cw e%0d timeout_err", e), 32'(timeout_err), 32'd0);
            chk($sformatf("cw e%0d ready", e),       32'(ready),       32'(e >= 32));
        end
        chk("cw retry_cnt", 32'(retry_cnt), 32'd0);

        // ---------------- Scenario 4/6: lock losses in RUN -----------------
        lock = 1'b1;
        do_reset("s4");
        restart_to_run("s4");
        for (int n = 1; n <= 20; n++) begin
            lock = 1'b0;                      // after edge E
            step(2);                          // E+2: still running
            chk($sformatf("s4 n%0d sys_rst_n hold", n), 32'(sys_rst_n), 32'd1);
            step(1);                          // E+3: dropped
            chk($sformatf("s4 n%0d sys_rst_n drop", n), 32'(sys_rst_n), 32'd0);
            chk($sformatf("s4 n%0d ready drop", n),     32'(ready),     32'd0);
            chk($sformatf("s4 n%0d loss_cnt", n),       32'(loss_cnt),  32'(exp_loss(n)));
            step(1);
            lock = 1'b1;                      // after edge F
            step(10);                         // F+10
            chk($sformatf("s4 n%0d ready pre", n), 32'(ready), 32'd0);
            step(1);                          // F+11: RUN again
            chk($sformatf("s4 n%0d ready run", n),     32'(ready),     32'd1);
            chk($sformatf("s4 n%0d sys_rst_n run", n), 32'(sys_rst_n), 32'd1);
            chk($sformatf("s4 n%0d pll_reset", n),     32'(pll_reset), 32'd0);
        end
        chk("s4 timeout_err", 32'(timeout_err), 32'd0);

        // ---------------- Scenario 5b: reset mid-RUN -----------------------
        step(3);
        chk("s5b pre ready", 32'(ready), 32'd1);
        do_reset("s5b");
        restart_to_run("s5b");
        chk("s5b loss_cnt", 32'(loss_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
